// File: rtl/game_turn_ctrl_if.sv
// Interface carrying the game controller's UI-side and AI-side signals.
// The controller takes the slave modport; the host/UI side takes the master modport.
interface game_turn_ctrl_if #(
    parameter int ROWS  = 6,
    parameter int COLS  = 6,
    parameter int IDX_W = 3
);
    localparam int CNT_W = $clog2(ROWS*COLS+1);

    logic [1:0]          i_mode;
    logic                i_ai_first;
    logic                i_start;
    logic                i_surrender;
    logic                i_prestep;
    logic [IDX_W-1:0]    i_row;
    logic [IDX_W-1:0]    i_col;
    logic                i_player_done;
    logic                i_ai_valid;
    logic [IDX_W-1:0]    i_ai_row;
    logic [IDX_W-1:0]    i_ai_col;
    logic                o_ai_req;
    logic [1:0]          o_ai_level;
    logic [2*ROWS*COLS-1:0] o_board;
    logic [IDX_W-1:0]    o_row;
    logic [IDX_W-1:0]    o_col;
    logic                o_aidone;
    logic                o_illegal;
    logic                o_turn;
    logic [CNT_W-1:0]    o_move_cnt;
    logic [2:0]          o_state;
    logic [1:0]          o_result;

    modport slave (
        input  i_mode, i_ai_first, i_start, i_surrender, i_prestep,
               i_row, i_col, i_player_done, i_ai_valid, i_ai_row, i_ai_col,
        output o_ai_req, o_ai_level, o_board, o_row, o_col, o_aidone,
               o_illegal, o_turn, o_move_cnt, o_state, o_result
    );

    modport master (
        output i_mode, i_ai_first, i_start, i_surrender, i_prestep,
               i_row, i_col, i_player_done, i_ai_valid, i_ai_row, i_ai_col,
        input  o_ai_req, o_ai_level, o_board, o_row, o_col, o_aidone,
               o_illegal, o_turn, o_move_cnt, o_state, o_result
    );
endinterface

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for human/AI or human/human games on a ROWS x COLS board,
// with move validation, bounded undo history, surrender, AI timeout and draw.
module game_turn_ctrl #(
    parameter int ROWS       = 6,
    parameter int COLS       = 6,
    parameter int IDX_W      = 3,
    parameter int HIST_DEPTH = 36,
    parameter int AI_TIMEOUT = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    game_turn_ctrl_if.slave  bus
);
    localparam int NCELL = ROWS*COLS;
    localparam int CNT_W = $clog2(NCELL+1);
    localparam int IW    = 2*IDX_W;
    localparam int HW    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int TW    = $clog2(AI_TIMEOUT+1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCELL-1);
    // OVER is entered exactly AI_TIMEOUT cycles after the o_ai_req pulse.
    localparam logic [TW-1:0]    TMO_LAST = TW'(AI_TIMEOUT-2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_TURN  = 3'd1,
        AI_REQ  = 3'd2,
        AI_WAIT = 3'd3,
        COMMIT  = 3'd4,
        UNDO    = 3'd5,
        OVER    = 3'd6
    } state_t;

    state_t state, state_nxt, undo_ret, undo_to;

    logic [NCELL-1:0][1:0]           cells;
    logic [HIST_DEPTH-1:0][IW-1:0]   hist;
    logic [CNT_W-1:0]                move_cnt, undo_k;
    logic [IDX_W-1:0]                row, col, pend_row, pend_col;
    logic [1:0]                      mode, result, result_nxt, undo_left, undo_n;
    logic                            ai_first, turn, illegal, aidone;
    logic                            illegal_nxt, aidone_nxt;
    logic [TW-1:0]                   tmo;

    logic                            is_2p, p_legal, a_legal;
    logic [IW-1:0]                   p_idx, a_idx, c_idx, pop_idx;
    logic [IW-1:0]                   pop_ent, top_ent;
    logic [1:0]                      human_win, ai_win, surr_win;

    function automatic logic [IW-1:0] cell_idx(input logic [IDX_W-1:0] r,
                                               input logic [IDX_W-1:0] c);
        return IW'(r) * IW'(COLS) + IW'(c);
    endfunction

    always_comb begin
        is_2p     = (mode == 2'd3);
        p_idx     = cell_idx(bus.i_row, bus.i_col);
        a_idx     = cell_idx(bus.i_ai_row, bus.i_ai_col);
        c_idx     = cell_idx(pend_row, pend_col);
        p_legal   = ({1'b0, bus.i_row} < (IDX_W+1)'(ROWS)) &&
                    ({1'b0, bus.i_col} < (IDX_W+1)'(COLS)) && (cells[p_idx] == 2'd0);
        a_legal   = ({1'b0, bus.i_ai_row} < (IDX_W+1)'(ROWS)) &&
                    ({1'b0, bus.i_ai_col} < (IDX_W+1)'(COLS)) && (cells[a_idx] == 2'd0);
        pop_ent   = hist[HW'(move_cnt - CNT_W'(1))];
        top_ent   = (move_cnt >= CNT_W'(2)) ? hist[HW'(move_cnt - CNT_W'(2))] : '0;
        pop_idx   = cell_idx(pop_ent[IW-1:IDX_W], pop_ent[IDX_W-1:0]);
        // Result codes name the winning side by move order, not by who is human.
        human_win = ai_first ? 2'd2 : 2'd1;
        ai_win    = ai_first ? 2'd1 : 2'd2;
        surr_win  = is_2p ? (turn ? 2'd1 : 2'd2) : ai_win;
        undo_k    = is_2p ? CNT_W'(1) : CNT_W'(2);
    end

    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        aidone_nxt  = 1'b0;
        result_nxt  = result;
        undo_n      = 2'd0;
        undo_to     = P_TURN;
        case (state)
            IDLE, OVER: begin
                if (bus.i_start) begin
                    state_nxt  = (bus.i_mode != 2'd3 && bus.i_ai_first) ? AI_REQ : P_TURN;
                    result_nxt = 2'd0;
                end
            end
            P_TURN: begin
                if (bus.i_surrender) begin
                    state_nxt  = OVER;
                    result_nxt = surr_win;
                end else if (bus.i_prestep) begin
                    if (!is_2p && ai_first && move_cnt == CNT_W'(1)) begin
                        state_nxt = UNDO;
                        undo_n    = 2'd1;
                        undo_to   = AI_REQ;
                    end else if (move_cnt < undo_k) begin
                        illegal_nxt = 1'b1;
                    end else begin
                        state_nxt = UNDO;
                        undo_n    = is_2p ? 2'd1 : 2'd2;
                    end
                end else if (bus.i_player_done) begin
                    if (p_legal) state_nxt   = COMMIT;
                    else         illegal_nxt = 1'b1;
                end
            end
            AI_REQ: state_nxt = AI_WAIT;
            AI_WAIT: begin
                if (bus.i_surrender) begin
                    state_nxt  = OVER;
                    result_nxt = surr_win;
                end else if (bus.i_ai_valid) begin
                    if (a_legal) begin
                        state_nxt  = COMMIT;
                        aidone_nxt = 1'b1;
                    end else begin
                        state_nxt  = OVER;
                        result_nxt = human_win;
                    end
                end else if (tmo == TMO_LAST) begin
                    state_nxt  = OVER;
                    result_nxt = human_win;
                end
            end
            COMMIT: begin
                if (move_cnt == LAST_CNT) begin
                    state_nxt  = OVER;
                    result_nxt = 2'd3;
                end else if (!is_2p && turn == ai_first) begin
                    state_nxt = AI_REQ;
                end else begin
                    state_nxt = P_TURN;
                end
            end
            UNDO: if (undo_left == 2'd1) state_nxt = undo_ret;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cells     <= '0;
            hist      <= '0;
            move_cnt  <= '0;
            row       <= '0;
            col       <= '0;
            pend_row  <= '0;
            pend_col  <= '0;
            mode      <= '0;
            ai_first  <= 1'b0;
            turn      <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
            aidone    <= 1'b0;
            tmo       <= '0;
            undo_left <= '0;
            undo_ret  <= P_TURN;
        end else begin
            illegal <= illegal_nxt;
            aidone  <= aidone_nxt;
            result  <= result_nxt;
            case (state)
                IDLE, OVER: begin
                    if (bus.i_start) begin
                        cells    <= '0;
                        hist     <= '0;
                        move_cnt <= '0;
                        row      <= '0;
                        col      <= '0;
                        turn     <= 1'b0;
                        mode     <= bus.i_mode;
                        ai_first <= bus.i_ai_first;
                    end
                end
                P_TURN: begin
                    if (state_nxt == COMMIT) begin
                        pend_row <= bus.i_row;
                        pend_col <= bus.i_col;
                    end
                    if (state_nxt == UNDO) begin
                        undo_left <= undo_n;
                        undo_ret  <= undo_to;
                    end
                end
                AI_REQ: tmo <= '0;
                AI_WAIT: begin
                    tmo <= tmo + TW'(1);
                    if (state_nxt == COMMIT) begin
                        pend_row <= bus.i_ai_row;
                        pend_col <= bus.i_ai_col;
                    end
                end
                COMMIT: begin
                    cells[c_idx]          <= {turn, ~turn};
                    hist[HW'(move_cnt)]   <= {pend_row, pend_col};
                    move_cnt              <= move_cnt + CNT_W'(1);
                    row                   <= pend_row;
                    col                   <= pend_col;
                    turn                  <= ~turn;
                end
                UNDO: begin
                    cells[pop_idx] <= 2'd0;
                    move_cnt       <= move_cnt - CNT_W'(1);
                    turn           <= ~turn;
                    row            <= top_ent[IW-1:IDX_W];
                    col            <= top_ent[IDX_W-1:0];
                    undo_left      <= undo_left - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ai_req   = (state == AI_REQ);
    assign bus.o_ai_level = mode;
    assign bus.o_board    = cells;
    assign bus.o_row      = row;
    assign bus.o_col      = col;
    assign bus.o_aidone   = aidone;
    assign bus.o_illegal  = illegal;
    assign bus.o_turn     = turn;
    assign bus.o_move_cnt = move_cnt;
    assign bus.o_state    = state;
    assign bus.o_result   = result;
endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench: a 6x6 1P controller (short AI timeout) and a 2x2 2P controller.
module tb_game_turn_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;
    logic [71:0] exp_b;
    int   req_seen;

    always #5 clk = ~clk;

    game_turn_ctrl_if #(.ROWS(6), .COLS(6), .IDX_W(3)) a();
    game_turn_ctrl_if #(.ROWS(2), .COLS(2), .IDX_W(1)) b();

    game_turn_ctrl #(.ROWS(6), .COLS(6), .IDX_W(3), .HIST_DEPTH(36), .AI_TIMEOUT(100))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(a));
    game_turn_ctrl #(.ROWS(2), .COLS(2), .IDX_W(1), .HIST_DEPTH(4), .AI_TIMEOUT(100))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(b));

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic a_start(input logic [1:0] m, input logic af);
        a.i_mode = m; a.i_ai_first = af; a.i_start = 1'b1;
        step(); a.i_start = 1'b0;
    endtask

    task automatic a_done(input logic [2:0] r, input logic [2:0] c);
        a.i_row = r; a.i_col = c; a.i_player_done = 1'b1;
        step(); a.i_player_done = 1'b0;
    endtask

    // from P_TURN: commit then land in AI_REQ
    task automatic human_move(input logic [2:0] r, input logic [2:0] c);
        a_done(r, c); step();
    endtask

    // from AI_REQ: wait, answer, commit, land in P_TURN
    task automatic ai_move(input logic [2:0] r, input logic [2:0] c);
        step();
        a.i_ai_row = r; a.i_ai_col = c; a.i_ai_valid = 1'b1;
        step(); a.i_ai_valid = 1'b0;
        step();
    endtask

    task automatic b_done(input logic r, input logic c);
        b.i_row = r; b.i_col = c; b.i_player_done = 1'b1;
        step(); b.i_player_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        total++; if (a.o_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", a.o_state); else pass_cnt++;
        total++; if (a.o_board !== 72'd0) $display("FAIL reset_board: got %0h want 0", a.o_board); else pass_cnt++;
        total++; if ({a.o_move_cnt, a.o_turn, a.o_result, a.o_ai_level, a.o_ai_req, a.o_illegal, a.o_aidone} !== '0)
            $display("FAIL reset_outs: got %0h want 0", {a.o_move_cnt, a.o_turn, a.o_result, a.o_ai_level, a.o_ai_req, a.o_illegal, a.o_aidone}); else pass_cnt++;
        total++; if (b.o_state !== 3'd0) $display("FAIL reset_state_b: got %0d want 0", b.o_state); else pass_cnt++;
    endtask

    task automatic test_2p_draw();
        b.i_mode = 2'd3; b.i_ai_first = 1'b0; b.i_start = 1'b1;
        step(); b.i_start = 1'b0;
        b_done(1'b0, 1'b0); step();
        b_done(1'b0, 1'b1); step();
        b_done(1'b1, 1'b0); step();
        b_done(1'b1, 1'b1); step();
        total++; if (b.o_state !== 3'd6) $display("FAIL draw_state: got %0d want 6", b.o_state); else pass_cnt++;
        total++; if (b.o_result !== 2'd3) $display("FAIL draw_result: got %0d want 3", b.o_result); else pass_cnt++;
        total++; if (b.o_board !== 8'h99) $display("FAIL draw_board: got %0h want 99", b.o_board); else pass_cnt++;
        total++; if (b.o_move_cnt !== 3'd4) $display("FAIL draw_cnt: got %0d want 4", b.o_move_cnt); else pass_cnt++;
        b.i_start = 1'b1; step(); b.i_start = 1'b0;
        total++; if ({b.o_state, b.o_board, b.o_turn, b.o_result} !== {3'd1, 8'h00, 1'b0, 2'd0})
            $display("FAIL restart_b: got %0h want %0h", {b.o_state, b.o_board, b.o_turn, b.o_result}, {3'd1, 8'h00, 1'b0, 2'd0}); else pass_cnt++;
    endtask

    task automatic test_1p_move();
        a_start(2'd1, 1'b0);
        total++; if (a.o_state !== 3'd1) $display("FAIL start_state: got %0d want 1", a.o_state); else pass_cnt++;
        total++; if (a.o_ai_level !== 2'd1) $display("FAIL ai_level: got %0d want 1", a.o_ai_level); else pass_cnt++;
        a_done(3'd0, 3'd0);
        total++; if (a.o_state !== 3'd4) $display("FAIL commit_latency: got %0d want 4", a.o_state); else pass_cnt++;
        step();
        req_seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (a.o_ai_req) req_seen++;
            if (i < 49) step();
        end
        total++; if (req_seen !== 1) $display("FAIL ai_req_pulses: got %0d want 1", req_seen); else pass_cnt++;
        a.i_ai_row = 3'd1; a.i_ai_col = 3'd1; a.i_ai_valid = 1'b1;
        step(); a.i_ai_valid = 1'b0;
        total++; if ({a.o_state, a.o_aidone} !== {3'd4, 1'b1}) $display("FAIL aidone: got %0h want %0h", {a.o_state, a.o_aidone}, {3'd4, 1'b1}); else pass_cnt++;
        step();
        exp_b = '0; exp_b[1:0] = 2'd1; exp_b[15:14] = 2'd2;
        total++; if (a.o_board !== exp_b) $display("FAIL board_1p: got %0h want %0h", a.o_board, exp_b); else pass_cnt++;
        total++; if ({a.o_move_cnt, a.o_turn, a.o_row, a.o_col, a.o_aidone} !== {6'd2, 1'b0, 3'd1, 3'd1, 1'b0})
            $display("FAIL after_ai: got %0h want %0h", {a.o_move_cnt, a.o_turn, a.o_row, a.o_col, a.o_aidone}, {6'd2, 1'b0, 3'd1, 3'd1, 1'b0}); else pass_cnt++;
    endtask

    task automatic test_illegal();
        a_done(3'd0, 3'd0);
        total++; if ({a.o_illegal, a.o_state} !== {1'b1, 3'd1}) $display("FAIL illegal_occupied: got %0h want %0h", {a.o_illegal, a.o_state}, {1'b1, 3'd1}); else pass_cnt++;
        step();
        total++; if (a.o_illegal !== 1'b0) $display("FAIL illegal_pulse_len: got %0d want 0", a.o_illegal); else pass_cnt++;
        a_done(3'd6, 3'd2);
        total++; if ({a.o_illegal, a.o_state} !== {1'b1, 3'd1}) $display("FAIL illegal_range: got %0h want %0h", {a.o_illegal, a.o_state}, {1'b1, 3'd1}); else pass_cnt++;
        total++; if ({a.o_board, a.o_move_cnt} !== {exp_b, 6'd2}) $display("FAIL illegal_nochange: got %0h want %0h", {a.o_board, a.o_move_cnt}, {exp_b, 6'd2}); else pass_cnt++;
        step();
    endtask

    task automatic test_undo();
        human_move(3'd2, 3'd2);
        ai_move(3'd3, 3'd3);
        total++; if (a.o_move_cnt !== 6'd4) $display("FAIL undo_setup: got %0d want 4", a.o_move_cnt); else pass_cnt++;
        a.i_prestep = 1'b1; step(); a.i_prestep = 1'b0;
        total++; if (a.o_state !== 3'd5) $display("FAIL undo_enter: got %0d want 5", a.o_state); else pass_cnt++;
        step();
        total++; if ({a.o_state, a.o_move_cnt, a.o_row, a.o_col} !== {3'd5, 6'd3, 3'd2, 3'd2})
            $display("FAIL undo_pop1: got %0h want %0h", {a.o_state, a.o_move_cnt, a.o_row, a.o_col}, {3'd5, 6'd3, 3'd2, 3'd2}); else pass_cnt++;
        step();
        total++; if ({a.o_state, a.o_move_cnt, a.o_row, a.o_col, a.o_turn} !== {3'd1, 6'd2, 3'd1, 3'd1, 1'b0})
            $display("FAIL undo_pop2: got %0h want %0h", {a.o_state, a.o_move_cnt, a.o_row, a.o_col, a.o_turn}, {3'd1, 6'd2, 3'd1, 3'd1, 1'b0}); else pass_cnt++;
        total++; if (a.o_board !== exp_b) $display("FAIL undo_board: got %0h want %0h", a.o_board, exp_b); else pass_cnt++;
    endtask

    task automatic test_surrender_and_empty_undo();
        a.i_surrender = 1'b1; a.i_prestep = 1'b1; step();
        a.i_surrender = 1'b0; a.i_prestep = 1'b0;
        total++; if ({a.o_state, a.o_result} !== {3'd6, 2'd2}) $display("FAIL surrender: got %0h want %0h", {a.o_state, a.o_result}, {3'd6, 2'd2}); else pass_cnt++;
        a_start(2'd2, 1'b0);
        a.i_prestep = 1'b1; step(); a.i_prestep = 1'b0;
        total++; if ({a.o_illegal, a.o_state, a.o_move_cnt, a.o_board} !== {1'b1, 3'd1, 6'd0, 72'd0})
            $display("FAIL undo_empty: got %0h want %0h", {a.o_illegal, a.o_state, a.o_move_cnt}, {1'b1, 3'd1, 6'd0}); else pass_cnt++;
        step();
    endtask

    task automatic test_timeout();
        human_move(3'd0, 3'd0);
        total++; if (a.o_ai_req !== 1'b1) $display("FAIL tmo_req: got %0d want 1", a.o_ai_req); else pass_cnt++;
        repeat (99) step();
        total++; if (a.o_state !== 3'd3) $display("FAIL tmo_early: got %0d want 3", a.o_state); else pass_cnt++;
        step();
        total++; if ({a.o_state, a.o_result} !== {3'd6, 2'd1}) $display("FAIL tmo_over: got %0h want %0h", {a.o_state, a.o_result}, {3'd6, 2'd1}); else pass_cnt++;
    endtask

    task automatic test_ai_first_undo();
        a_start(2'd0, 1'b1);
        total++; if ({a.o_state, a.o_ai_req, a.o_result} !== {3'd2, 1'b1, 2'd0}) $display("FAIL ai_first_start: got %0h want %0h", {a.o_state, a.o_ai_req, a.o_result}, {3'd2, 1'b1, 2'd0}); else pass_cnt++;
        ai_move(3'd4, 3'd5);
        exp_b = '0; exp_b[59:58] = 2'd1;
        total++; if ({a.o_board, a.o_turn, a.o_state} !== {exp_b, 1'b1, 3'd1}) $display("FAIL ai_first_move: got %0h want %0h", a.o_board, exp_b); else pass_cnt++;
        a.i_prestep = 1'b1; step(); a.i_prestep = 1'b0;
        step();
        total++; if ({a.o_state, a.o_board, a.o_move_cnt, a.o_turn, a.o_row, a.o_col} !== {3'd2, 72'd0, 6'd0, 1'b0, 3'd0, 3'd0})
            $display("FAIL ai_first_undo: got state %0d cnt %0d want state 2 cnt 0", a.o_state, a.o_move_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_midgame();
        step();
        total++; if (a.o_state !== 3'd3) $display("FAIL mid_wait: got %0d want 3", a.o_state); else pass_cnt++;
        rst = 1'b1; step(); rst = 1'b0;
        total++; if ({a.o_state, a.o_board, a.o_move_cnt, a.o_ai_req, a.o_ai_level, a.o_result} !== '0)
            $display("FAIL mid_reset: got state %0d cnt %0d want 0", a.o_state, a.o_move_cnt); else pass_cnt++;
        a.i_ai_row = 3'd0; a.i_ai_col = 3'd0; a.i_ai_valid = 1'b1; step(); a.i_ai_valid = 1'b0;
        step();
        total++; if ({a.o_state, a.o_board, a.o_aidone} !== '0) $display("FAIL late_ai_valid: got state %0d board %0h want 0", a.o_state, a.o_board); else pass_cnt++;
    endtask

    initial begin
        {a.i_mode, a.i_ai_first, a.i_start, a.i_surrender, a.i_prestep, a.i_row, a.i_col,
         a.i_player_done, a.i_ai_valid, a.i_ai_row, a.i_ai_col} = '0;
        {b.i_mode, b.i_ai_first, b.i_start, b.i_surrender, b.i_prestep, b.i_row, b.i_col,
         b.i_player_done, b.i_ai_valid, b.i_ai_row, b.i_ai_col} = '0;
        test_reset();
        test_2p_draw();
        test_1p_move();
        test_illegal();
        test_undo();
        test_surrender_and_empty_undo();
        test_timeout();
        test_ai_first_undo();
        test_reset_midgame();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
